// File: rtl/aes_core_arbiter.sv
// Round-robin front end that time-shares a single AES-128 encrypt core
// between NREQ requesters, with a watchdog that turns a hung core into an
// error response instead of a deadlock.
//
// state | meaning
// IDLE  | searching for a requester from the rr pointer upward
// ISSUE | one-cycle start pulse to the core, watchdog cleared
// WAIT  | waiting for core_finish or watchdog expiry
// RESP  | response held until resp_ready
module aes_core_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*128-1:0]    req_in,
  input  logic [NREQ*128-1:0]    req_key,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [127:0]           resp_data,
  output logic [IDW-1:0]         resp_id,
  output logic                   resp_err,
  output logic                   core_start,
  output logic [127:0]           core_in,
  output logic [127:0]           core_key,
  input  logic                   core_finish,
  input  logic [127:0]           core_out,
  output logic                   busy
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant;
  logic             grant_vld;
  logic [IDW:0]     cand_sum;
  logic [IDW-1:0]   cand;
  logic [WDW-1:0]   wd_cnt;
  logic             wd_expired;

  // Grant search: scan offsets high to low so the nearest valid requester
  // at or above the pointer is the last (winning) assignment.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_sum = {1'b0, rr_ptr} + (IDW + 1)'(k);
      if (cand_sum >= NREQ_W) cand_sum = cand_sum - NREQ_W;
      cand = cand_sum[IDW-1:0];
      if (req_valid[cand]) begin
        grant     = cand;
        grant_vld = 1'b1;
      end
    end
  end

  assign wd_expired = (wd_cnt == WDW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a finish in the same cycle as expiry takes priority
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_vld) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (core_finish || wd_expired) state_nxt = S_RESP;
      S_RESP:  if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the accept strobe is masked during reset
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_vld && !rst) req_ready[grant] = 1'b1;
    core_start = (state == S_ISSUE);
    resp_valid = (state == S_RESP);
    busy       = (state != S_IDLE);
  end

  // Request capture, pointer advance, watchdog and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      core_in   <= '0;
      core_key  <= '0;
      resp_id   <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            core_in  <= req_in[128*grant +: 128];
            core_key <= req_key[128*grant +: 128];
            resp_id  <= grant;
            rr_ptr   <= (grant == LAST_ID) ? '0 : grant + 1'b1;
          end
        end
        S_ISSUE: wd_cnt <= '0;
        S_WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (core_finish) begin
            resp_data <= core_out;
            resp_err  <= 1'b0;
          end else if (wd_expired) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: AES-128 reference core model, requester driver,
// transaction-level expectation model checked every cycle, directed tests.
module tb_aes_core_arbiter;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 64;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*128-1:0] req_in, req_key;
  logic                resp_valid;
  logic                resp_ready = 1'b1;
  logic [127:0]        resp_data;
  logic [IDW-1:0]      resp_id;
  logic                resp_err;
  logic                core_start;
  logic [127:0]        core_in, core_key;
  logic                core_finish = 1'b0;
  logic [127:0]        core_out = '0;
  logic                busy;

  logic [127:0] pt_a [NREQ];
  logic [127:0] key_a[NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign req_in[128*gi +: 128]  = pt_a[gi];
    assign req_key[128*gi +: 128] = key_a[gi];
  end

  always #5 clk = ~clk;

  aes_core_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_in(req_in), .req_key(req_key), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id),
    .resp_err(resp_err), .core_start(core_start), .core_in(core_in),
    .core_key(core_key), .core_finish(core_finish), .core_out(core_out),
    .busy(busy)
  );

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox[256];

  function automatic logic [7:0] gmul(input logic [7:0] a_i, input logic [7:0] b_i);
    logic [7:0] a, b, p;
    a = a_i; b = b_i; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      if (a[7]) a = (a << 1) ^ 8'h1b;
      else      a = a << 1;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [7:0]  s[16], t[16];
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) s[j] = sbox[s[j]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
      s = t;
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
    return o;
  endfunction

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    int           id;
    logic [127:0] data;
    logic         err;
  } resp_t;
  resp_t rlog[$];
  int    glog[$];

  function automatic int rid(input int k);
    return (k < rlog.size()) ? rlog[k].id : -1;
  endfunction
  function automatic logic [127:0] rdat(input int k);
    return (k < rlog.size()) ? rlog[k].data : 128'hx;
  endfunction
  function automatic logic rerr(input int k);
    return (k < rlog.size()) ? rlog[k].err : 1'bx;
  endfunction
  function automatic int gid(input int k);
    return (k < glog.size()) ? glog[k] : -1;
  endfunction

  // ---------------- requester driver ----------------
  int target[NREQ];
  int served[NREQ];
  initial begin
    logic [NREQ-1:0] hs;
    for (int i = 0; i < NREQ; i++) begin target[i] = 0; served[i] = 0; end
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) begin served[i]++; glog.push_back(i); end
        req_valid[i] = (served[i] < target[i]);
      end
    end
  end

  // ---------------- core model ----------------
  int  lat = 5;
  bit  hang = 1'b0;
  int  inj_req = 0;
  initial begin
    int ccnt, inj_done;
    logic [127:0] cin, ckey;
    ccnt = 0; inj_done = 0; cin = '0; ckey = '0;
    forever begin
      @(posedge clk);
      #3;
      core_finish = 1'b0;
      if (ccnt > 0) begin
        ccnt--;
        if (ccnt == 0) begin
          core_finish = 1'b1;
          core_out    = aes_enc(cin, ckey);
        end
      end
      if (core_start && !hang) begin
        ccnt = lat; cin = core_in; ckey = core_key;
      end
      if (inj_req != inj_done) begin
        inj_done    = inj_req;
        core_finish = 1'b1;
        core_out    = {4{$urandom}};
      end
    end
  end

  // ---------------- transaction model + per-cycle compare ----------------
  int hs_cyc = 0, start_cyc = 0, rise_cyc = 0, start_count = 0;
  initial begin
    int m_ptr, m_acc, m_id, g, elapsed;
    bit m_free, m_have, m_err, prev_rv;
    logic [127:0] m_in, m_key, m_data;
    logic [NREQ-1:0] exp_rdy;
    m_ptr = 0; m_acc = 0; m_id = 0; m_free = 1; m_have = 0; m_err = 0;
    m_in = '0; m_key = '0; m_data = '0; prev_rv = 0;
    forever begin
      @(negedge clk);
      cyc++;
      g = -1;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      if (check_en) begin
        exp_rdy = '0;
        if (m_free && !rst && g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("busy", busy, !m_free);
        chk("core_start", core_start, !m_free && cyc == m_acc + 1);
        chk("resp_valid", resp_valid, m_have);
        chk("core_in", core_in, m_in);
        chk("core_key", core_key, m_key);
        chk("resp_data", resp_data, m_data);
        chk("resp_id", resp_id, m_id);
        chk("resp_err", resp_err, m_err);
        if (resp_valid && resp_ready && !rst) begin
          rlog.push_back('{id: int'(resp_id), data: resp_data, err: resp_err});
          if (m_have && !m_err) chk("cipher", resp_data, aes_enc(m_in, m_key));
        end
        if (|(req_valid & req_ready)) hs_cyc = cyc;
        if (core_start) begin start_cyc = cyc; start_count++; end
        if (resp_valid && !prev_rv) rise_cyc = cyc;
      end
      prev_rv = resp_valid;
      // what the next rising edge does
      if (rst) begin
        m_ptr = 0; m_free = 1; m_have = 0; m_err = 0; m_id = 0;
        m_in = '0; m_key = '0; m_data = '0;
      end else if (m_free) begin
        if (g >= 0) begin
          m_free = 0; m_acc = cyc; m_id = g;
          m_in = pt_a[g]; m_key = key_a[g];
          m_ptr = (g + 1) % NREQ;
        end
      end else if (m_have) begin
        if (resp_ready) begin m_free = 1; m_have = 0; end
      end else if (cyc > m_acc + 1) begin
        elapsed = cyc - m_acc - 1;
        if (core_finish) begin
          m_data = core_out; m_err = 0; m_have = 1;
        end else if (elapsed == TIMEOUT) begin
          m_data = '0; m_err = 1; m_have = 1;
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_resps(input int n, input int budget);
    int k = 0;
    while (rlog.size() < n && k < budget) begin tick(1); k++; end
    chk("wait_resp_count", rlog.size(), n);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!resp_valid && k < budget) begin tick(1); k++; end
    chk("wait_resp_valid", resp_valid, 1'b1);
  endtask

  task automatic wait_busy(input int budget);
    int k = 0;
    while (!busy && k < budget) begin tick(1); k++; end
    chk("wait_busy", busy, 1'b1);
  endtask

  initial begin
    logic [7:0] inv;
    int n_start;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int i = 0; i < NREQ; i++) begin
      pt_a[i]  = {4{$urandom}};
      key_a[i] = {4{$urandom}};
    end

    tick(1);
    check_en = 1'b1;
    tick(1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_resp_data", resp_data, '0);
    chk("rst_core_in", core_in, '0);
    rst = 1'b0;

    // FIPS-197 vector through requester 2
    pt_a[2]  = 128'h00112233445566778899aabbccddeeff;
    key_a[2] = 128'h000102030405060708090a0b0c0d0e0f;
    target[2] = 1;
    wait_resps(1, 100);
    chk("fips_start_latency", start_cyc - hs_cyc, 1);
    chk("fips_data", rdat(0), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("fips_id", rid(0), 2);
    chk("fips_err", rerr(0), 1'b0);
    tick(3);

    // all requesters continuously valid from pointer 0, shortest core latency
    rst = 1'b1; tick(1); rst = 1'b0;
    rlog.delete();
    lat = 1;
    for (int i = 0; i < NREQ; i++) target[i] += 2;
    wait_resps(8, 200);
    for (int k = 0; k < 8; k++) chk("rr_order", rid(k), k % 4);
    tick(3);

    // backpressure
    rlog.delete();
    lat = 3;
    resp_ready = 1'b0;
    target[1]++;
    wait_valid(100);
    target[0]++;
    n_start = start_count;
    repeat (20) begin
      tick(1);
      chk("bp_valid", resp_valid, 1'b1);
      chk("bp_data", resp_data, aes_enc(pt_a[1], key_a[1]));
      chk("bp_id", resp_id, 1);
      chk("bp_req_ready", req_ready, '0);
    end
    chk("bp_no_start", start_count, n_start);
    resp_ready = 1'b1;
    wait_resps(2, 100);
    chk("bp_next_id", rid(1), 0);
    tick(3);

    // watchdog timeout, late finish ignored, then normal service
    rlog.delete();
    hang = 1'b1;
    resp_ready = 1'b0;
    target[3]++;
    wait_valid(TIMEOUT + 50);
    tick(1);
    chk("to_latency", rise_cyc - start_cyc, 65);
    chk("to_err", resp_err, 1'b1);
    chk("to_data", resp_data, '0);
    inj_req++;
    tick(3);
    chk("to_hold_err", resp_err, 1'b1);
    chk("to_hold_data", resp_data, '0);
    resp_ready = 1'b1;
    tick(3);
    inj_req++;
    tick(3);
    chk("to_idle_after_late", busy, 1'b0);
    hang = 1'b0;
    lat = 2;
    target[0]++;
    wait_resps(2, 100);
    chk("post_to_data", rdat(1), aes_enc(pt_a[0], key_a[0]));
    chk("post_to_err", rerr(1), 1'b0);
    // finish on the very cycle the watchdog expires
    lat = TIMEOUT;
    target[2]++;
    wait_resps(3, 200);
    chk("coincide_err", rerr(2), 1'b0);
    chk("coincide_data", rdat(2), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    tick(3);

    // reset in the middle of WAIT
    rlog.delete();
    hang = 1'b1;
    target[2]++;
    wait_busy(20);
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_resp_valid", resp_valid, 1'b0);
    chk("mid_rst_core_start", core_start, 1'b0);
    chk("mid_rst_core_in", core_in, '0);
    chk("mid_rst_core_key", core_key, '0);
    chk("mid_rst_resp_data", resp_data, '0);
    chk("mid_rst_resp_id", resp_id, 0);
    chk("mid_rst_resp_err", resp_err, 1'b0);
    hang = 1'b0;
    lat = 4;
    tick(TIMEOUT + 5);
    chk("mid_rst_no_resp", rlog.size(), 0);
    target[1]++;
    target[3]++;
    wait_resps(2, 100);
    chk("mid_rst_first", rid(0), 1);
    chk("mid_rst_second", rid(1), 3);
    tick(3);

    // pointer wrap: bring pointer to 3, then only 3 and 0 valid
    rlog.delete();
    glog.delete();
    target[2]++;
    wait_resps(1, 100);
    target[3]++;
    target[0]++;
    wait_resps(3, 200);
    for (int i = 0; i < NREQ; i++) target[i]++;
    wait_resps(7, 300);
    chk("wrap_g0", gid(0), 2);
    chk("wrap_g1", gid(1), 3);
    chk("wrap_g2", gid(2), 0);
    chk("wrap_ptr_end", gid(3), 1);
    chk("wrap_resp3", rid(1), 3);
    chk("wrap_resp0", rid(2), 0);
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Round-robin scheduler that shares one AES128_encrypt core between NREQ independent requesters.
- Per request: accepts a plaintext/key pair, pulses the core's start, waits for finish, then returns the ciphertext tagged with the requester index.
- Sits between the traffic sources (stress generators, packet engines) and the single encrypt core.
- Includes a watchdog so a hung core cannot deadlock the requesters.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester index; must equal clog2(NREQ), minimum 1.
- TIMEOUT, 64, maximum cycles from start pulse to finish before an error response.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_in  input  NREQ*128  plaintexts; requester i at bits [128*i+127:128*i].
- req_key  input  NREQ*128  keys, same packing.
- resp_valid  output  1  response available.
- resp_ready  input  1  response consumer accept.
- resp_data  output  128  ciphertext; zero on error.
- resp_id  output  IDW  index of the served requester.
- resp_err  output  1  response produced by watchdog timeout.
- core_start  output  1  start pulse to the core.
- core_in  output  128  plaintext to the core.
- core_key  output  128  key to the core.
- core_finish  input  1  core done pulse.
- core_out  input  128  core ciphertext; valid in the cycle core_finish is high.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; rr pointer=0.
  - req_ready=0, resp_valid=0, resp_data=0, resp_id=0, resp_err=0.
  - core_start=0, core_in=0, core_key=0, busy=0.
  - Watchdog counter=0. Reset mid-operation abandons the in-flight request with no response; a late core_finish after reset is ignored.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching from rr pointer upward modulo NREQ.
  - On grant, req_ready[grant]=1 combinationally; the transfer completes that cycle.
  - Registers captured: core_in, core_key, resp_id <= grant; rr pointer <= (grant+1) mod NREQ; next state ISSUE.
  - With no valid request, stay in IDLE and hold the pointer.
- ISSUE:
  - core_start=1 for exactly this one cycle; watchdog cleared to 0; next state WAIT.
  - core_in/core_key stay stable from ISSUE through WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - On core_finish=1: resp_data <= core_out, resp_err <= 0, next state RESP.
  - Else if watchdog == TIMEOUT-1: resp_data <= 0, resp_err <= 1, next state RESP.
  - If finish and timeout coincide, finish wins (err=0).
- RESP:
  - resp_valid=1 with data/id/err stable until resp_ready=1; then IDLE next cycle.
  - req_ready stays 0 throughout; no new grant in the same cycle as the response handshake.
  - core_finish in RESP or IDLE is ignored, including late finish after a timeout.
- Latency: accept -> core_start is 1 cycle; core finish -> resp_valid is 1 cycle.
- Throughput: one request per (core latency + 3 cycles), given resp_ready held high.
- Fairness: with all NREQ requesters continuously valid, grants are 0,1,..,NREQ-1,0,... and no requester waits more than NREQ-1 other grants.
- req_valid deasserted before grant: no effect. After grant, the request is owned by the arbiter.
- busy = (state != IDLE).

Test Plan:
- Single request, FIPS-197 vector: requester 2 sends key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> core_start one cycle after accept; resp_data=69c4e0d86a7b0430d8cdb78070b4c55a, resp_id=2, resp_err=0.
- All 4 requesters valid continuously, 8 requests -> resp_id sequence 0,1,2,3,0,1,2,3; each ciphertext matches the reference model for its own key/pt.
- Backpressure: resp_ready held 0 for 20 cycles after resp_valid -> resp_data/id stable; req_ready all 0; no core_start until the handshake completes.
- Timeout: core model never asserts finish -> resp_valid exactly TIMEOUT+1 cycles after core_start (the +1 is the RESP register stage), with resp_err=1 and resp_data=0. A later finish pulse is ignored; the next request is served normally.
- Reset mid-WAIT: rst asserted for 1 cycle -> all outputs return to reset values next cycle; the pending response is never emitted; rr pointer=0, so requesters 1 and 3 valid grant 1 first.
- Pointer wrap: pointer at 3, only requesters 3 and 0 valid -> grant 3, then 0; pointer ends at 1.
